// File: rtl/nano_pkg.sv
// Shared widths, loader state encoding and memory array type for the
// NanoCPU boot memory.
package nano_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CNT  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_SUM  = 3'd4,
    S_RUN  = 3'd5,
    S_ERR  = 3'd6
  } ld_state_e;

  typedef logic [DATA_W-1:0] mem_t [0:DEPTH-1];

endpackage

// File: rtl/nano_ram.sv
// 256 x 16 storage: combinational read port, synchronous write port.
// The array is deliberately unreset so contents survive a loader restart.
module nano_ram
  import nano_pkg::*;
(
  input  logic              ck,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  mem_t mem_q;

  always_ff @(posedge ck) begin
    if (wen) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/nano_boot_mem.sv
// Boot memory for NanoCPU: parses a checksummed byte frame into RAM, holds the
// CPU in reset until a good frame arrives, then hands the write port to the CPU.
module nano_boot_mem
  import nano_pkg::*;
#(
  parameter int unsigned RST_HOLD = 2
) (
  input  logic              ck,
  input  logic              rst,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataW,
  output logic [DATA_W-1:0] dataR,
  input  logic              ce,
  input  logic              we
);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        chk_q, chk_d;
  logic [3:0]        hold_q, hold_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic              ld_wr;
  logic              cpu_wr;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  assign ld_ready = !rst && (state_q inside {S_IDLE, S_CNT, S_HI, S_LO, S_SUM});
  assign accept   = ld_valid && ld_ready;

  // The CPU may only write once its reset has actually been released.
  assign ld_wr     = (state_q == S_LO) && accept;
  assign cpu_wr    = (state_q == S_RUN) && !cpu_rst_q && ce && we;
  assign ram_waddr = ld_wr ? wptr_q : address;
  assign ram_wdata = ld_wr ? {hi_q, ld_data} : dataW;

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    chk_d     = chk_q;
    hold_d    = hold_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: if (accept) begin
        wptr_d  = ld_data;
        chk_d   = ld_data;
        state_d = S_CNT;
      end
      S_CNT: if (accept) begin
        cnt_d   = (ld_data == 8'd0) ? 9'd256 : {1'b0, ld_data};
        chk_d   = chk_q ^ ld_data;
        state_d = S_HI;
      end
      S_HI: if (accept) begin
        hi_d    = ld_data;
        chk_d   = chk_q ^ ld_data;
        state_d = S_LO;
      end
      S_LO: if (accept) begin
        wptr_d  = wptr_q + 8'd1;
        cnt_d   = cnt_q - 9'd1;
        chk_d   = chk_q ^ ld_data;
        state_d = (cnt_q == 9'd1) ? S_SUM : S_HI;
      end
      S_SUM: if (accept) begin
        if (ld_data == chk_q) begin
          state_d = S_RUN;
          done_d  = 1'b1;
          hold_d  = 4'(RST_HOLD);
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      // cpu_rst drops on the edge that takes the hold counter to zero.
      S_RUN: if (hold_q != 4'd0) begin
        hold_d = hold_q - 4'd1;
        if (hold_q == 4'd1) begin
          cpu_rst_d = 1'b0;
        end
      end
      S_ERR: begin
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      chk_q     <= '0;
      hold_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      chk_q     <= chk_d;
      hold_q    <= hold_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cpu_rst   = cpu_rst_q;
  assign load_done = done_q;
  assign load_err  = err_q;

  nano_ram u_ram (
    .ck    (ck),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .wen   (ld_wr || cpu_wr),
    .raddr (address),
    .rdata (dataR)
  );

endmodule

// File: tb/tb_nano_boot_mem.sv
// Directed bench for nano_boot_mem: frames are driven byte by byte, expected
// memory words are queued as they are sent and read back through dataR.
module tb_nano_boot_mem;

  localparam int HOLD = 2;

  logic        ck = 1'b0;
  logic        rst;
  logic [7:0]  ld_data;
  logic        ld_valid;
  logic        ld_ready;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;
  logic [7:0]  address;
  logic [15:0] dataW;
  logic [15:0] dataR;
  logic        ce;
  logic        we;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] frame_words[$];
  int          total = 0;
  int          bad   = 0;

  always #5 ck = ~ck;

  nano_boot_mem #(.RST_HOLD(HOLD)) dut (
    .ck        (ck),
    .rst       (rst),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .cpu_rst   (cpu_rst),
    .load_done (load_done),
    .load_err  (load_err),
    .address   (address),
    .dataW     (dataW),
    .dataR     (dataR),
    .ce        (ce),
    .we        (we)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A byte offered during reset must be ignored.
  task automatic do_reset();
    rst = 1'b1; ce = 1'b0; we = 1'b0;
    ld_data = 8'h33; ld_valid = 1'b1;
    @(negedge ck);
    @(negedge ck);
    check("rst_ld_ready", 16'(ld_ready), 16'd0);
    check("rst_cpu_rst", 16'(cpu_rst), 16'd1);
    check("rst_load_done", 16'(load_done), 16'd0);
    check("rst_load_err", 16'(load_err), 16'd0);
    ld_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_ready", 16'(ld_ready), 16'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge ck);
    t = 0;
    while (!ld_ready && t < 20) begin
      @(negedge ck);
      t++;
    end
    check("ready_wait", 16'(ld_ready), 16'd1);
    ld_data  = b;
    ld_valid = 1'b1;
    @(negedge ck);
    ld_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input int gap,
                            input logic [7:0] corrupt);
    logic [7:0]  chk;
    logic [15:0] w;
    int          n;
    chk = a ^ c;
    send_byte(a, gap);
    send_byte(c, gap);
    n = (c == 8'd0) ? 256 : int'(c);
    for (int i = 0; i < n; i++) begin
      w = frame_words[i];
      send_byte(w[15:8], gap);
      send_byte(w[7:0], gap);
      chk = chk ^ w[15:8] ^ w[7:0];
      sb_q.push_back('{addr: a + 8'(i), data: w});
    end
    send_byte(chk ^ corrupt, gap);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      address = e.addr;
      #1;
      check($sformatf("mem[%02h]", e.addr), dataR, e.data);
      @(negedge ck);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int hi_cnt;
    rst = 1'b1; ld_data = '0; ld_valid = 1'b0;
    address = '0; dataW = '0; ce = 1'b0; we = 1'b0;

    // Count 0 means a full 256-word image.
    do_reset();
    frame_words.delete();
    for (int i = 0; i < 256; i++) frame_words.push_back(16'h5A00 ^ 16'(i * 257));
    send_frame(8'h80, 8'h00, 0, 8'h00);
    #1;
    check("c0_done", 16'(load_done), 16'd1);
    drain();

    // Known background for the addresses later tests must leave alone.
    do_reset();
    frame_words.delete();
    for (int i = 0; i < 18; i++) frame_words.push_back(16'hA000 + 16'(i));
    send_frame(8'h10, 8'h12, 0, 8'h00);
    drain();

    // Good frame, hold timing and CPU write gating.
    do_reset();
    frame_words.delete();
    frame_words.push_back(16'h01E0);
    frame_words.push_back(16'h01F1);
    send_frame(8'h00, 8'h02, 0, 8'h00);
    address = 8'h21; dataW = 16'hBEEF; ce = 1'b1; we = 1'b1;
    #1;
    check("t1_done", 16'(load_done), 16'd1);
    check("t1_err", 16'(load_err), 16'd0);
    check("t1_ready", 16'(ld_ready), 16'd0);
    check("t1_cpu_rst_e0", 16'(cpu_rst), 16'd1);
    @(negedge ck);
    ce = 1'b0; we = 1'b0;
    #1;
    check("t1_cpu_rst_e1", 16'(cpu_rst), 16'd1);
    check("t1_blocked_wr", dataR, 16'hA011);
    @(negedge ck);
    check("t1_cpu_rst_e2", 16'(cpu_rst), 16'd0);
    ce = 1'b1; we = 1'b1;
    @(negedge ck);
    ce = 1'b0; we = 1'b0;
    #1;
    check("t1_cpu_wr", dataR, 16'hBEEF);
    drain();

    // Bad checksum: words land but the CPU never leaves reset.
    do_reset();
    send_frame(8'h00, 8'h02, 0, 8'h07);
    #1;
    check("t2_err", 16'(load_err), 16'd1);
    check("t2_done", 16'(load_done), 16'd0);
    check("t2_ready", 16'(ld_ready), 16'd0);
    hi_cnt = 0;
    repeat (50) begin
      @(negedge ck);
      if (cpu_rst) hi_cnt++;
    end
    check("t2_cpu_rst_50", 16'(hi_cnt), 16'd50);
    drain();

    // Write pointer wraps from FF to 00.
    do_reset();
    frame_words.delete();
    frame_words.push_back(16'hAABB);
    frame_words.push_back(16'hCCDD);
    send_frame(8'hFF, 8'h02, 0, 8'h00);
    #1;
    check("t3_done", 16'(load_done), 16'd1);
    drain();

    // ld_valid high only every other cycle.
    do_reset();
    frame_words.delete();
    frame_words.push_back(16'h1111);
    frame_words.push_back(16'h2222);
    frame_words.push_back(16'h3333);
    send_frame(8'h40, 8'h03, 1, 8'h00);
    #1;
    check("t4_done", 16'(load_done), 16'd1);
    check("t4_err", 16'(load_err), 16'd0);
    drain();

    // Reset in the middle of word 1 keeps word 0 and drops the rest.
    do_reset();
    send_byte(8'h10, 0);
    send_byte(8'h03, 0);
    send_byte(8'hC3, 0);
    send_byte(8'hC4, 0);
    send_byte(8'hD5, 0);
    do_reset();
    frame_words.delete();
    frame_words.push_back(16'h1234);
    send_frame(8'h20, 8'h01, 0, 8'h00);
    #1;
    check("t5_done", 16'(load_done), 16'd1);
    sb_q.push_back('{addr: 8'h10, data: 16'hC3C4});
    sb_q.push_back('{addr: 8'h11, data: 16'hA001});
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nano_boot_mem.md
# nano_boot_mem

Program/data memory for the NanoCPU with an integrated byte-stream boot loader. After reset it accepts a framed byte stream and writes it into a 256 x 16 memory. It holds the CPU in reset until a frame with a valid checksum has been loaded, then hands the memory port to the CPU. It sits directly upstream of NanoCPU and replaces the behavioural memory in the CPU bench.

## Interface
Parameters:
- RST_HOLD, 2, cycles cpu_rst stays high after the load completes; legal range 1..15.

Ports (clock: one clock; reset is synchronous and active-high):
- ck  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- ld_data  in  8  loader byte
- ld_valid  in  1  ld_data valid
- ld_ready  out  1  loader can accept a byte
- cpu_rst  out  1  reset to NanoCPU rst
- load_done  out  1  frame loaded, CPU running (sticky)
- load_err  out  1  checksum mismatch (sticky)
- address  in  8  CPU address
- dataW  in  16  CPU write data
- dataR  out  16  read data = mem[address], combinational
- ce  in  1  CPU chip enable
- we  in  1  CPU write enable

## Operation
- Frame, in byte order: start address A, count C (0 means 256), 2·N data bytes (each word high byte first, N = C or 256), checksum S.
- S must equal the XOR of every preceding frame byte.
- A byte is accepted on any rising edge with ld_valid & ld_ready.
- FSM states:
  - IDLE: accept A; load wptr ← A, clear chk. Go to CNT.
  - CNT: accept C; load the remaining-word counter (9 bits). Go to HI.
  - HI: latch the high byte. Go to LO.
  - LO: write mem[wptr] ← {hi, byte} on the same edge; wptr += 1, wrapping mod 256; decrement the counter. If the counter is now 0, go to SUM, else HI.
  - SUM: if byte == chk, go to RUN, else ERR.
  - RUN: ld_ready = 0; CPU owns writes.
  - ERR: ld_ready = 0; cpu_rst stays 1; load_err = 1. Only rst exits.
- chk ← chk ^ byte on every accepted byte in IDLE, CNT, HI and LO.
- ld_ready = 1 in IDLE, CNT, HI, LO and SUM, and 0 while rst is high.
- CPU writes: mem[address] ← dataW on an edge with ce & we, but only in RUN and only after cpu_rst has fallen. CPU writes during loading are dropped.
- dataR is always mem[address]; reads are never blocked.
- The memory array has no reset. Contents survive rst; a new frame overwrites only the addresses it covers.

## Timing
- Reset values: state IDLE, cpu_rst 1, load_done 0, load_err 0, ld_ready 0 while rst is high, chk 0, hold counter 0.
- ld_ready is 1 on the first cycle after rst falls.
- Word write latency: the LO byte's accepting edge writes memory, so dataR shows the new word in the next cycle.
- RUN entry edge: load_done ← 1 and the hold counter ← RST_HOLD.
- cpu_rst falls exactly RST_HOLD cycles after the RUN entry edge.
- ld_valid low in any load state stalls with no state change. No timeout.
- Wrap-around: A = 0xFF with C = 2 writes 0xFF then 0x00.
- C = 0 loads 256 words.
- rst mid-frame returns to IDLE next edge and drops the partial frame. Words already written remain.
- rst in RUN reasserts cpu_rst and restarts loading.
- ld_valid and rst in the same cycle: the byte is not accepted.

## Structure
- Package nano_pkg holds:
  - ADDR_W = 8 and DATA_W = 16
  - typedef enum of loader states (IDLE, CNT, HI, LO, SUM, RUN, ERR)
  - typedef of the 256 x 16 memory word array
- Sub-module nano_ram: 256 x 16, one combinational read port, one synchronous write port (waddr, wdata, wen).
  - Top level muxes the write port: the loader in LO, the CPU in RUN.
  - FSM, checksum and hold counter stay in nano_boot_mem.

## Test plan
- Frame 00 02 01 E0 01 F1 13 -> mem[0]=01E0, mem[1]=01F1, load_done=1, load_err=0; cpu_rst falls RST_HOLD cycles after the SUM byte edge.
- Same frame with checksum 14 -> load_err=1, ld_ready=0, cpu_rst stays 1 for at least 50 cycles; words still written.
- Frame FF 02 AA BB CC DD S (S = XOR of the first six bytes) -> mem[FF]=AABB, mem[00]=CCDD.
- ld_valid toggled every other cycle across the whole frame -> same memory contents as back-to-back bytes; no duplicate or skipped bytes.
- rst pulse after the HI byte of word 1 of frame 10 03 ..., then full frame 20 01 12 34 S -> mem[10] keeps word 0, mem[20]=1234, mem[11] unchanged.
- In RUN, CPU ce=1 we=1 address=21 dataW=BEEF -> dataR=BEEF next cycle. Same write attempted while cpu_rst=1 -> mem[21] unchanged.
